alu_writeback: RTL and testbench

- Downstream companion of the 2-stage ALU. It carries each issued op's destination/control tag through a shadow pipeline that matches the ALU's 2-enabled-edge latency.
- It pairs the tag with the ALU `Result` and retires the op as a register-file write and/or a control-flow redirect.
- It squashes wrong-path ops behind a taken branch and publishes a pending-write mask for upstream hazard detection.

---
 rtl/alu_writeback_pkg.sv | 57 +++++
 rtl/alu_writeback_kind_decode.sv | 21 ++
 rtl/alu_writeback.sv | 115 +++++++++++
 tb/tb_alu_writeback.sv | 429 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_writeback_pkg.sv
// Shared types for the ALU writeback stage: data/pc/instruction types, op kind and shadow tag.
package alu_writeback_pkg;

    localparam int unsigned DATA_W        = 32;
    localparam int unsigned PC_W          = 10;
    localparam int unsigned WB_NUM_REGS   = 16;
    localparam int unsigned WB_REG_ADDR_W = $clog2(WB_NUM_REGS);

    typedef logic [DATA_W-1:0] data_t;
    typedef logic [PC_W-1:0]   instruction_memory_address_t;

    // ALU opcode; encodings above JAL are unused and decode as NONE.
    typedef enum logic [4:0] {
        NOP  = 5'd0,
        ADD  = 5'd1,
        SUB  = 5'd2,
        MUL  = 5'd3,
        ABS  = 5'd4,
        SLT  = 5'd5,
        SEQ  = 5'd6,
        SNEZ = 5'd7,
        MIN  = 5'd8,
        SLL  = 5'd9,
        ADDI = 5'd10,
        MULI = 5'd11,
        SLLI = 5'd12,
        SEQI = 5'd13,
        DIV  = 5'd14,
        DIVI = 5'd15,
        BEQO = 5'd16,
        BEQZ = 5'd17,
        JAL  = 5'd18
    } alu_instruction_t;

    // What an op does when it retires.
    typedef enum logic [1:0] {
        NONE   = 2'd0,
        WRITE  = 2'd1,
        BRANCH = 2'd2,
        JUMP   = 2'd3
    } alu_kind_t;

    // Destination/control tag carried alongside the op through the ALU latency.
    typedef struct packed {
        logic                        valid;
        alu_kind_t                   kind;
        logic [WB_REG_ADDR_W-1:0]    rd;
        instruction_memory_address_t link;
        instruction_memory_address_t target;
    } wb_tag_t;

    // True for kinds that produce a register-file write (rd permitting).
    function automatic logic writes_reg(input alu_kind_t kind);
        return (kind == WRITE) || (kind == JUMP);
    endfunction

endpackage

// File: rtl/alu_writeback_kind_decode.sv
// Combinational opcode -> retire-kind classifier, shared with upstream hazard logic.
module alu_kind_decode
    import alu_writeback_pkg::*;
(
    input  alu_instruction_t instruction,
    output alu_kind_t        kind
);

    // Classify the opcode; unknown encodings retire as nothing.
    always_comb begin
        kind = NONE;
        case (instruction)
            ADD, SUB, MUL, ABS, SLT, SEQ, SNEZ, MIN, SLL,
            ADDI, MULI, SLLI, SEQI, DIV, DIVI: kind = WRITE;
            BEQO, BEQZ:                        kind = BRANCH;
            JAL:                               kind = JUMP;
            default:                           kind = NONE;
        endcase
    end

endmodule

// File: rtl/alu_writeback.sv
// Writeback companion of the 2-stage ALU: shadows each op's tag for two enabled
// edges, then retires it as a register write and/or a redirect, squashing the
// younger ops behind a taken control transfer.
module alu_writeback
    import alu_writeback_pkg::*;
#(
    parameter int unsigned NUM_REGS   = WB_NUM_REGS,
    parameter int unsigned REG_ADDR_W = $clog2(NUM_REGS)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        enable,
    input  logic                        in_valid,
    input  alu_instruction_t            in_instruction,
    input  logic [REG_ADDR_W-1:0]       in_rd,
    input  instruction_memory_address_t in_pc,
    input  data_t                       in_imm,
    input  data_t                       alu_result,
    output logic                        wr_en,
    output logic [REG_ADDR_W-1:0]       wr_addr,
    output data_t                       wr_data,
    output logic                        redirect,
    output instruction_memory_address_t redirect_pc,
    output logic [NUM_REGS-1:0]         pending
);

    alu_kind_t in_kind;
    wb_tag_t   in_tag;
    wb_tag_t   s1_q;
    wb_tag_t   s2_q;
    wb_tag_t   s1_d;
    wb_tag_t   s2_d;
    logic      retire;

    alu_kind_decode u_kind_decode (
        .instruction (in_instruction),
        .kind        (in_kind)
    );

    // Build the tag for the op being presented; link/target wrap at pc width.
    always_comb begin
        in_tag        = '0;
        in_tag.valid  = in_valid;
        in_tag.kind   = in_kind;
        in_tag.rd     = in_rd;
        in_tag.link   = in_pc + PC_W'(1);
        in_tag.target = in_pc + PC_W'(in_imm);
    end

    // s2 lines up with alu_result; only an enabled cycle consumes it.
    assign retire = enable & s2_q.valid;

    // Retire decode: everything is zero unless the op in s2 is retiring.
    always_comb begin
        wr_en       = 1'b0;
        wr_addr     = '0;
        wr_data     = '0;
        redirect    = 1'b0;
        redirect_pc = '0;
        if (retire) begin
            case (s2_q.kind)
                WRITE: begin
                    wr_en   = (s2_q.rd != '0);
                    wr_addr = s2_q.rd;
                    wr_data = alu_result;
                end
                BRANCH: begin
                    if (alu_result[0]) begin
                        redirect    = 1'b1;
                        redirect_pc = s2_q.target;
                    end
                end
                JUMP: begin
                    redirect    = 1'b1;
                    redirect_pc = alu_result[PC_W-1:0];
                    wr_en       = (s2_q.rd != '0);
                    wr_addr     = s2_q.rd;
                    wr_data     = DATA_W'(s2_q.link);
                end
                default: ;
            endcase
        end
    end

    // Next shadow contents; a redirect squashes both younger ops.
    always_comb begin
        s1_d       = in_tag;
        s1_d.valid = in_valid & ~redirect;
        s2_d       = s1_q;
        s2_d.valid = s1_q.valid & ~redirect;
    end

    // Shadow pipeline registers, advancing in lockstep with the ALU.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_q <= '0;
            s2_q <= '0;
        end else if (enable) begin
            s1_q <= s1_d;
            s2_q <= s2_d;
        end
    end

    // Outstanding register writes, for upstream hazard detection.
    always_comb begin
        pending = '0;
        if (s1_q.valid && writes_reg(s1_q.kind) && (s1_q.rd != '0)) begin
            pending[s1_q.rd] = 1'b1;
        end
        if (s2_q.valid && writes_reg(s2_q.kind) && (s2_q.rd != '0)) begin
            pending[s2_q.rd] = 1'b1;
        end
    end

endmodule

// File: tb/tb_alu_writeback.sv
// Self-checking bench for alu_writeback: directed scenarios plus a randomized run
// against an in-order queue model of the ops in flight.
`timescale 1ns/1ps
module tb_alu_writeback;
    import alu_writeback_pkg::*;

    localparam int unsigned NR = WB_NUM_REGS;
    localparam int unsigned RW = WB_REG_ADDR_W;
    localparam int unsigned VW = 2 + NR + RW + DATA_W + PC_W;
    localparam int K_NONE   = 0;
    localparam int K_WRITE  = 1;
    localparam int K_BRANCH = 2;
    localparam int K_JUMP   = 3;

    logic                        clk = 1'b0;
    logic                        rst;
    logic                        enable;
    logic                        in_valid;
    alu_instruction_t            in_instruction;
    logic [RW-1:0]               in_rd;
    instruction_memory_address_t in_pc;
    data_t                       in_imm;
    data_t                       alu_result;
    logic                        wr_en;
    logic [RW-1:0]               wr_addr;
    data_t                       wr_data;
    logic                        redirect;
    instruction_memory_address_t redirect_pc;
    logic [NR-1:0]               pending;

    // Value the ALU stand-in produces for the op presented this cycle.
    data_t in_res = '0;
    data_t alu_p1 = '0;
    data_t alu_p2 = '0;

    int total = 0;
    int bad   = 0;

    alu_writeback dut (
        .clk            (clk),
        .rst            (rst),
        .enable         (enable),
        .in_valid       (in_valid),
        .in_instruction (in_instruction),
        .in_rd          (in_rd),
        .in_pc          (in_pc),
        .in_imm         (in_imm),
        .alu_result     (alu_result),
        .wr_en          (wr_en),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .pending        (pending)
    );

    always #5 clk = ~clk;

    // Stand-in for the 2-stage ALU: result appears two enabled edges after capture.
    always @(posedge clk) begin
        if (enable) begin
            alu_p1 <= in_valid ? in_res : data_t'($urandom);
            alu_p2 <= alu_p1;
        end
    end
    assign alu_result = alu_p2;

    // ---------------- reference model ----------------
    typedef struct {
        int                          kind;
        logic [RW-1:0]               rd;
        instruction_memory_address_t link;
        instruction_memory_address_t target;
        data_t                       res;
        int                          age;
    } op_t;

    op_t q[$];
    logic [VW-1:0] exp_v;
    logic [VW-1:0] msk_v;
    logic          exp_redir;

    function automatic int ref_kind(input alu_instruction_t op);
        case (op)
            ADD, SUB, MUL, ABS, SLT, SEQ, SNEZ, MIN, SLL,
            ADDI, MULI, SLLI, SEQI, DIV, DIVI: return K_WRITE;
            BEQO, BEQZ:                        return K_BRANCH;
            JAL:                               return K_JUMP;
            default:                           return K_NONE;
        endcase
    endfunction

    function automatic logic [VW-1:0] obs();
        return {wr_en, redirect, pending, wr_addr, wr_data, redirect_pc};
    endfunction

    // Expected outputs for the current cycle from the ops in flight.
    task automatic model_expect();
        logic                        we, rdr, mwa, mrp;
        logic [RW-1:0]               wa;
        data_t                       wd;
        instruction_memory_address_t rp;
        logic [NR-1:0]               pend;
        we = 0; rdr = 0; wa = '0; wd = '0; rp = '0; pend = '0; mwa = 1; mrp = 1;
        foreach (q[i]) begin
            if ((q[i].kind == K_WRITE || q[i].kind == K_JUMP) && q[i].rd != 0) pend[q[i].rd] = 1'b1;
        end
        if (enable && q.size() > 0 && q[0].age == 2) begin
            case (q[0].kind)
                K_WRITE: begin
                    we = (q[0].rd != 0); wa = q[0].rd; wd = q[0].res;
                end
                K_BRANCH: begin
                    rdr = q[0].res[0]; rp = q[0].target;
                end
                K_JUMP: begin
                    rdr = 1; rp = q[0].res[PC_W-1:0];
                    we = (q[0].rd != 0); wa = q[0].rd; wd = DATA_W'(q[0].link);
                end
                default: ;
            endcase
            mwa = we;
            mrp = rdr;
        end
        exp_redir = rdr;
        exp_v = {we, rdr, pend, wa, wd, rp};
        msk_v = {1'b1, 1'b1, {NR{1'b1}}, {RW{mwa}}, {DATA_W{mwa}}, {PC_W{mrp}}};
    endtask

    // Model state change at an active edge.
    task automatic model_advance();
        op_t e;
        if (!rst) begin
            q.delete();
        end else if (enable) begin
            if (exp_redir) begin
                q.delete();
            end else begin
                if (q.size() > 0 && q[0].age == 2) void'(q.pop_front());
                foreach (q[i]) q[i].age++;
                if (in_valid) begin
                    e.kind   = ref_kind(in_instruction);
                    e.rd     = in_rd;
                    e.link   = in_pc + PC_W'(1);
                    e.target = in_pc + in_imm[PC_W-1:0];
                    e.res    = in_res;
                    e.age    = 1;
                    q.push_back(e);
                end
            end
        end
    endtask

    task automatic present(input logic en, input logic v, input alu_instruction_t op,
                           input int rd, input int pc, input data_t imm, input data_t res);
        enable = en; in_valid = v; in_instruction = op;
        in_rd = RW'(rd); in_pc = PC_W'(pc); in_imm = imm; in_res = res;
        #1;
        model_expect();
    endtask

    task automatic idle(input logic en);
        present(en, 1'b0, NOP, 0, 0, '0, '0);
    endtask

    task automatic advance();
        @(posedge clk);
        model_advance();
        @(negedge clk);
    endtask

    function automatic alu_instruction_t pick_op();
        int r;
        r = $urandom_range(0, 21);
        if (r < 19) return alu_instruction_t'(5'(r));
        return alu_instruction_t'(5'($urandom_range(19, 31)));
    endfunction

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            present(1'b1, 1'b1, ADD, 2, 0, '0, 32'h5);
            total++;
            if (obs() !== VW'(0)) begin
                bad++; $display("FAIL reset c%0d: got %h want 0", c, obs());
            end
            advance();
        end
        rst = 1'b1;
    endtask

    task automatic test_addi();
        int wr_cycles = 0;
        for (int c = 0; c < 4; c++) begin
            if (c == 0) present(1'b1, 1'b1, ADDI, 3, 'h40, 32'd7, 32'd12);
            else        idle(1'b1);
            total++;
            if ((obs() & msk_v) !== (exp_v & msk_v)) begin
                bad++; $display("FAIL addi c%0d: got %h want %h", c, obs() & msk_v, exp_v & msk_v);
            end
            total++;
            if (pending[3] !== (c == 1 || c == 2)) begin
                bad++; $display("FAIL addi_pending3 c%0d: got %b", c, pending[3]);
            end
            if (c == 2) begin
                total++;
                if ({wr_en, wr_addr, wr_data} !== {1'b1, RW'(3), DATA_W'(12)}) begin
                    bad++; $display("FAIL addi_write: got %b/%0d/%0d want 1/3/12", wr_en, wr_addr, wr_data);
                end
            end
            if (wr_en === 1'b1) wr_cycles++;
            advance();
        end
        total++;
        if (wr_cycles != 1) begin
            bad++; $display("FAIL addi_once: got %0d writes want 1", wr_cycles);
        end
    endtask

    task automatic test_stall();
        int wr_cycles;
        int wr_at;
        for (int v = 0; v < 2; v++) begin
            wr_cycles = 0; wr_at = -1;
            for (int c = 0; c < 7; c++) begin
                if (c == 0) present(1'b1, 1'b1, ADDI, 3, 'h44, 32'd7, 32'd12);
                else        idle(!(c >= 1 + v && c <= 3 + v));
                total++;
                if ((obs() & msk_v) !== (exp_v & msk_v)) begin
                    bad++; $display("FAIL stall v%0d c%0d: got %h want %h", v, c, obs() & msk_v, exp_v & msk_v);
                end
                if (wr_en === 1'b1) begin wr_cycles++; wr_at = c; end
                advance();
            end
            total++;
            if (wr_cycles != 1 || wr_at != 5) begin
                bad++; $display("FAIL stall_once v%0d: got %0d writes at c%0d want 1 at c5", v, wr_cycles, wr_at);
            end
        end
    endtask

    task automatic test_branch_flush();
        int bad_writes = 0;
        for (int c = 0; c < 6; c++) begin
            case (c)
                0: present(1'b1, 1'b1, BEQZ, 0, 'h10, 32'h08, 32'd1);
                1: present(1'b1, 1'b1, ADD, 4, 'h11, '0, 32'h44);
                2: present(1'b1, 1'b1, SUB, 5, 'h12, '0, 32'h55);
                default: idle(1'b1);
            endcase
            total++;
            if ((obs() & msk_v) !== (exp_v & msk_v)) begin
                bad++; $display("FAIL branch c%0d: got %h want %h", c, obs() & msk_v, exp_v & msk_v);
            end
            if (c == 2) begin
                total++;
                if (redirect !== 1'b1 || redirect_pc !== PC_W'('h18)) begin
                    bad++; $display("FAIL branch_taken: got %b/%h want 1/018", redirect, redirect_pc);
                end
            end
            if (c == 3) begin
                total++;
                if (pending[5:4] !== 2'b00) begin
                    bad++; $display("FAIL branch_pending: got %b want 00", pending[5:4]);
                end
            end
            if (wr_en === 1'b1) bad_writes++;
            advance();
        end
        total++;
        if (bad_writes != 0) begin
            bad++; $display("FAIL branch_squash: got %0d writes want 0", bad_writes);
        end
    endtask

    task automatic test_branch_not_taken();
        int redirs = 0;
        for (int c = 0; c < 5; c++) begin
            case (c)
                0: present(1'b1, 1'b1, BEQO, 0, 'h30, 32'h05, 32'd0);
                1: present(1'b1, 1'b1, ADD, 6, 'h31, '0, 32'h66);
                default: idle(1'b1);
            endcase
            total++;
            if ((obs() & msk_v) !== (exp_v & msk_v)) begin
                bad++; $display("FAIL beqo c%0d: got %h want %h", c, obs() & msk_v, exp_v & msk_v);
            end
            if (c == 3) begin
                total++;
                if ({wr_en, wr_addr, wr_data} !== {1'b1, RW'(6), DATA_W'('h66)}) begin
                    bad++; $display("FAIL beqo_follow: got %b/%0d/%h want 1/6/66", wr_en, wr_addr, wr_data);
                end
            end
            if (redirect === 1'b1) redirs++;
            advance();
        end
        total++;
        if (redirs != 0) begin
            bad++; $display("FAIL beqo_redirect: got %0d want 0", redirs);
        end
    endtask

    task automatic test_jal();
        for (int v = 0; v < 2; v++) begin
            for (int c = 0; c < 4; c++) begin
                if (c == 0) present(1'b1, 1'b1, JAL, (v == 0) ? 1 : 0, 'h20, 32'h04, 32'h24);
                else        idle(1'b1);
                total++;
                if ((obs() & msk_v) !== (exp_v & msk_v)) begin
                    bad++; $display("FAIL jal v%0d c%0d: got %h want %h", v, c, obs() & msk_v, exp_v & msk_v);
                end
                if (c == 2) begin
                    total++;
                    if (v == 0 && ({redirect, redirect_pc, wr_en, wr_addr, wr_data} !==
                                   {1'b1, PC_W'('h24), 1'b1, RW'(1), DATA_W'('h21)})) begin
                        bad++; $display("FAIL jal_r1: got %b/%h/%b/%0d/%h want 1/024/1/1/21",
                                        redirect, redirect_pc, wr_en, wr_addr, wr_data);
                    end
                    if (v == 1 && ({redirect, wr_en} !== 2'b10)) begin
                        bad++; $display("FAIL jal_r0: got redirect=%b wr_en=%b want 1/0", redirect, wr_en);
                    end
                end
                advance();
            end
        end
    endtask

    task automatic test_back_to_back();
        data_t last = '0;
        int    n    = 0;
        for (int c = 0; c < 5; c++) begin
            case (c)
                0: present(1'b1, 1'b1, ADD, 7, 'h50, '0, 32'hAAAA0001);
                1: present(1'b1, 1'b1, MUL, 7, 'h51, '0, 32'hBBBB0002);
                default: idle(1'b1);
            endcase
            total++;
            if ((obs() & msk_v) !== (exp_v & msk_v)) begin
                bad++; $display("FAIL b2b c%0d: got %h want %h", c, obs() & msk_v, exp_v & msk_v);
            end
            if (wr_en === 1'b1 && wr_addr == RW'(7)) begin last = wr_data; n++; end
            advance();
        end
        total++;
        if (n != 2 || last !== 32'hBBBB0002) begin
            bad++; $display("FAIL b2b_order: got %0d writes last %h want 2 last bbbb0002", n, last);
        end
    endtask

    task automatic test_reset_midflight();
        int rises = 0;
        present(1'b1, 1'b1, ADD, 2, 'h60, '0, 32'h22);
        advance();
        present(1'b1, 1'b1, ADD, 3, 'h61, '0, 32'h33);
        advance();
        idle(1'b1);
        total++;
        if ((obs() & msk_v) !== (exp_v & msk_v)) begin
            bad++; $display("FAIL midrst_pre: got %h want %h", obs() & msk_v, exp_v & msk_v);
        end
        #2 rst = 1'b0;
        #1;
        total++;
        if (obs() !== VW'(0)) begin
            bad++; $display("FAIL midrst_async: got %h want 0", obs());
        end
        advance();
        advance();
        rst = 1'b1;
        for (int c = 0; c < 6; c++) begin
            idle(1'b1);
            if (wr_en !== 1'b0 || pending !== '0) rises++;
            advance();
        end
        total++;
        if (rises != 0) begin
            bad++; $display("FAIL midrst_after: got %0d active cycles want 0", rises);
        end
    endtask

    task automatic test_random();
        logic             en;
        logic             hold = 1'b0;
        logic             hv = 1'b0;
        alu_instruction_t hop = NOP;
        int               hrd = 0;
        int               hpc = 0;
        data_t            himm = '0;
        data_t            hres = '0;
        int               errs = 0;
        for (int c = 0; c < 400; c++) begin
            en = ($urandom_range(0, 3) != 0);
            if (!hold) begin
                hv   = ($urandom_range(0, 2) != 0);
                hop  = pick_op();
                hrd  = $urandom_range(0, NR - 1);
                hpc  = $urandom_range(0, 1023);
                himm = $urandom;
                hres = $urandom;
            end
            present(en, hv, hop, hrd, hpc, himm, hres);
            total++;
            if ((obs() & msk_v) !== (exp_v & msk_v)) begin
                bad++; errs++;
                if (errs <= 10) $display("FAIL random c%0d: got %h want %h", c, obs() & msk_v, exp_v & msk_v);
            end
            hold = hv && !en;
            advance();
        end
    endtask

    initial begin
        enable = 1'b0; in_valid = 1'b0; in_instruction = NOP;
        in_rd = '0; in_pc = '0; in_imm = '0;
        test_reset();
        test_addi();
        test_stall();
        test_branch_flush();
        test_branch_not_taken();
        test_jal();
        test_back_to_back();
        test_reset_midflight();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
